cell3_stim_driver: RTL and testbench
====================================

// Module: cell3_stim_driver
// PURPOSE
//   Stimulus driver and response reader for a 3-input, 1-output library cell under test.
//   Drives the cell's IN1/IN2/IN3 pins through all 8 input vectors in Gray order and
//   samples its Q pin after a settle window.
//   Compares Q against a truth-table parameter and counts mismatches and Q toggles.
//   Sits in the power-characterisation bench between the test controller and the cell.
// PARAMETERS
//   TRUTH       8'h80  expected Q per vector; bit index = {IN3,IN2,IN1} (8'h80 = AND3)
//   NUM_PASSES  4      full 8-vector sweeps per run; legal range >= 1; 0 behaves as 1
//   SETTLE_CYC  2      cycles from vector apply to Q sample; legal range >= 1
//   CNT_W       16     width of ERR_CNT and TOG_CNT
// PORTS
//   CLK      in   1      clock, rising edge
//   RST      in   1      asynchronous reset, active high
//   START    in   1      run request; single-cycle pulse, sampled in IDLE only
//   DUT_Q    in   1      Q pin of the cell under test
//   OUT_IN1  out  1      drives the cell's IN1 pin
//   OUT_IN2  out  1      drives the cell's IN2 pin
//   OUT_IN3  out  1      drives the cell's IN3 pin
//   BUSY     out  1      high from START acceptance until the DONE cycle
//   DONE     out  1      one-cycle pulse at end of run
//   FAIL     out  1      sticky: any mismatch this run
//   ERR_CNT  out  CNT_W  mismatch count, saturating
//   TOG_CNT  out  CNT_W  DUT_Q transition count while BUSY, saturating
// BEHAVIOUR
//   - Reset: every output is 0. FSM=IDLE. Vector index=0, pass count=0, prev_q=0.
//     RST mid-run aborts immediately; DONE is not produced.
//   - FSM states: IDLE -> APPLY -> SETTLE -> SAMPLE -> (APPLY | FIN) -> IDLE.
//   - IDLE: START=1 clears ERR_CNT/TOG_CNT/FAIL/prev_q/index/pass, sets BUSY, goes to APPLY.
//     START in any other state is ignored.
//   - APPLY: registers OUT_IN{3,2,1} = gray[index]. Gray order is
//     {3'b000,001,011,010,110,111,101,100} as {IN3,IN2,IN1}.
//   - SETTLE: waits SETTLE_CYC-1 cycles. SAMPLE: DUT_Q is sampled SETTLE_CYC cycles after APPLY.
//   - On sample, if DUT_Q != TRUTH[gray[index]], ERR_CNT+1 (saturates at all-ones) and FAIL=1.
//   - After SAMPLE: index+1. Index wraps 7->0 and increments pass.
//     After the last vector of pass NUM_PASSES, go to FIN; otherwise go to APPLY next cycle.
//   - Cycle cost: each vector takes SETTLE_CYC+1 cycles. A run is 8*NUM_PASSES*(SETTLE_CYC+1) cycles.
//   - FIN: OUT_IN* driven to 0, DONE=1 for exactly one cycle, BUSY=0 the same cycle, then IDLE.
//   - ERR_CNT/TOG_CNT/FAIL hold their values in IDLE until the next accepted START.
//   - Toggle count: every cycle while BUSY (FIN included), DUT_Q is compared with prev_q.
//     On a difference TOG_CNT+1 (saturating); prev_q <= DUT_Q.
//   - DUT_Q is treated as synchronous to CLK (registered by the bench wrapper); no synchroniser here.
// CONFIGURATION
//   CELL3_STIM_TOGCNT_EN defined:
//     toggle counter and prev_q register are built; TOG_CNT behaves as above.
//   Not defined:
//     no toggle logic is built; TOG_CNT is tied to 0. All other behaviour is identical.
// TESTING (defaults; run = 96 cycles; macro defined unless stated)
//   1. AND3 model on DUT_Q, START pulse -> BUSY 96 cycles, DONE pulse on the cycle after,
//      ERR_CNT=0, FAIL=0, TOG_CNT=8.
//   2. DUT_Q stuck 0 -> ERR_CNT=4, FAIL=1, TOG_CNT=0.
//   3. DUT_Q stuck 1 -> ERR_CNT=28, FAIL=1, TOG_CNT=1.
//   4. START re-pulsed at cycles 10 and 50 of a run -> ignored; DONE once at the original time;
//      counts equal those of test 1.
//   5. RST at cycle 40 -> all outputs 0 asynchronously, no DONE.
//      Next START -> clean run with test-1 results.
//   6. Macro undefined, AND3 model -> TOG_CNT=0 throughout; ERR_CNT=0, DONE timing unchanged.

Source files
------------

// File: rtl/cell3_stim_driver.sv
// Stimulus driver / response reader for a 3-input, 1-output library cell: Gray-order sweep, Q check, toggle count.
// Optional toggle counter built only when CELL3_STIM_TOGCNT_EN is defined; otherwise o_tog_cnt is tied to 0.
//
// state    | meaning
// S_IDLE   | waiting for i_start; results held
// S_APPLY  | latch gray[index] onto the cell inputs
// S_SETTLE | wait SETTLE_CYC-1 cycles for the cell to settle
// S_SAMPLE | compare i_dut_q with TRUTH, advance index/pass
// S_FIN    | cell inputs 0, one-cycle o_done, then idle
module cell3_stim_driver #(
   parameter logic [7:0] TRUTH      = 8'h80,
   parameter int         NUM_PASSES = 4,
   parameter int         SETTLE_CYC = 2,
   parameter int         CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_dut_q,
   output logic             o_in1,
   output logic             o_in2,
   output logic             o_in3,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fail,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_tog_cnt
);

   localparam int NP        = (NUM_PASSES < 1) ? 1 : NUM_PASSES;
   localparam int PASS_W    = $clog2(NP + 1);
   localparam int ST_W      = $clog2(SETTLE_CYC + 1);
   localparam int SETTLE_LD = (SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [2:0]         r_idx;
   logic [PASS_W-1:0]  r_pass;
   logic [ST_W-1:0]    r_settle;
   logic [2:0]         r_vec;
   logic               r_fail;
   logic [CNT_W-1:0]   r_err;
   logic [2:0]         w_gray;
   logic               w_exp;
   logic               w_last;
   logic               w_accept;
   logic               w_busy;
   logic               w_done;

   assign w_gray   = r_idx ^ (r_idx >> 1);
   assign w_exp    = TRUTH[w_gray];
   assign w_last   = (r_idx == 3'd7) && (r_pass == PASS_W'(NP - 1));
   assign w_accept = (r_state == S_IDLE) && i_start;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_APPLY;
         S_APPLY: begin
            w_busy = 1'b1;
            w_next = (SETTLE_CYC > 1) ? S_SETTLE : S_SAMPLE;
         end
         S_SETTLE: begin
            w_busy = 1'b1;
            if (r_settle == '0) w_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            w_busy = 1'b1;
            w_next = w_last ? S_FIN : S_APPLY;
         end
         S_FIN: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx    <= '0;
         r_pass   <= '0;
         r_settle <= '0;
         r_vec    <= '0;
         r_fail   <= 1'b0;
         r_err    <= '0;
      end else begin
         if (w_accept) begin
            r_idx  <= '0;
            r_pass <= '0;
            r_vec  <= '0;
            r_fail <= 1'b0;
            r_err  <= '0;
         end
         if (r_state == S_APPLY) begin
            r_vec    <= w_gray;
            r_settle <= ST_W'(SETTLE_LD);
         end
         if ((r_state == S_SETTLE) && (r_settle != '0))
            r_settle <= r_settle - 1'b1;
         if (r_state == S_SAMPLE) begin
            if (i_dut_q != w_exp) begin
               r_fail <= 1'b1;
               if (r_err != '1) r_err <= r_err + 1'b1;
            end
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_pass <= r_pass + 1'b1;
            // Park the cell inputs at 0 for the FIN cycle and beyond.
            if (w_last) r_vec <= '0;
         end
      end
   end

`ifdef CELL3_STIM_TOGCNT_EN
   logic             r_prev_q;
   logic [CNT_W-1:0] r_tog;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev_q <= 1'b0;
         r_tog    <= '0;
      end else if (w_accept) begin
         r_prev_q <= 1'b0;
         r_tog    <= '0;
      end else if (w_busy || w_done) begin
         if (i_dut_q != r_prev_q) begin
            r_prev_q <= i_dut_q;
            if (r_tog != '1) r_tog <= r_tog + 1'b1;
         end
      end
   end

   assign o_tog_cnt = r_tog;
`else
   assign o_tog_cnt = '0;
`endif

   assign {o_in3, o_in2, o_in1} = r_vec;
   assign o_busy    = w_busy;
   assign o_done    = w_done;
   assign o_fail    = r_fail;
   assign o_err_cnt = r_err;

endmodule

// File: tb/tb_cell3_stim_driver.sv
// Directed bench for cell3_stim_driver: AND3 / stuck-0 / stuck-1 cell models, START re-pulse, mid-run reset.
// Toggle expectations follow CELL3_STIM_TOGCNT_EN.
module tb_cell3_stim_driver;

   localparam int CNT_W = 16;

`ifdef CELL3_STIM_TOGCNT_EN
   localparam bit TOG_EN = 1'b1;
`else
   localparam bit TOG_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             q_model;
   logic             in1, in2, in3;
   logic             busy, done, fail;
   logic [CNT_W-1:0] err_cnt, tog_cnt;

   int               mode;        // 0 stuck-0, 1 stuck-1, 2 AND3
   int               n_tests = 0;
   int               n_fail  = 0;
   int               busy_n, done_n, done_at;
   logic [2:0]       gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                      3'b110, 3'b111, 3'b101, 3'b100};

   cell3_stim_driver #(
      .TRUTH(8'h80), .NUM_PASSES(4), .SETTLE_CYC(2), .CNT_W(CNT_W)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_dut_q(q_model),
      .o_in1(in1), .o_in2(in2), .o_in3(in3),
      .o_busy(busy), .o_done(done), .o_fail(fail),
      .o_err_cnt(err_cnt), .o_tog_cnt(tog_cnt)
   );

   always #5 clk = ~clk;

   // Registered cell model, as the bench wrapper would present it.
   always @(posedge clk) begin
      case (mode)
         0:       q_model <= 1'b0;
         1:       q_model <= 1'b1;
         default: q_model <= in1 & in2 & in3;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_fail"}, {31'd0, fail}, 0);
      chk({tag, "_in"},   {29'd0, in3, in2, in1}, 0);
      chk({tag, "_err"},  {16'd0, err_cnt}, 0);
      chk({tag, "_tog"},  {16'd0, tog_cnt}, 0);
   endtask

   // Pulse START, then observe each cycle at the falling edge (cycle 1 = first BUSY cycle).
   task automatic run(input bit repulse, input int rst_at);
      busy_n  = 0;
      done_n  = 0;
      done_at = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_at = c;
            chk("fin_in_zero", {29'd0, in3, in2, in1}, 0);
         end
         if ((c % 3 == 0) && (c <= 24))
            chk($sformatf("vec%0d", c / 3 - 1), {29'd0, in3, in2, in1},
                {29'd0, gray_tab[c / 3 - 1]});
         start = repulse && (c == 10 || c == 50);
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            chk_outs_zero("abort");
         end
         if (c == rst_at + 1) rst = 1'b0;
         if ((done_at > 0) && (c > done_at + 3)) break;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string tag, input int e_err, input int e_fail, input int e_tog);
      chk({tag, "_busy_cycles"}, busy_n, 96);
      chk({tag, "_done_at"},     done_at, 97);
      chk({tag, "_done_count"},  done_n, 1);
      chk({tag, "_err"},         {16'd0, err_cnt}, e_err);
      chk({tag, "_fail"},        {31'd0, fail}, e_fail);
      chk({tag, "_tog"},         {16'd0, tog_cnt}, TOG_EN ? e_tog : 0);
      repeat (5) @(negedge clk);
      chk({tag, "_err_hold"},    {16'd0, err_cnt}, e_err);
      chk({tag, "_fail_hold"},   {31'd0, fail}, e_fail);
      chk({tag, "_idle_busy"},   {31'd0, busy}, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 2;
      #2;
      chk_outs_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      mode = 2;
      run(1'b0, 0);
      check_run("and3", 0, 0, 8);

      mode = 0;
      run(1'b0, 0);
      check_run("stuck0", 4, 1, 0);

      mode = 1;
      run(1'b0, 0);
      check_run("stuck1", 28, 1, 1);

      mode = 2;
      run(1'b1, 0);
      check_run("repulse", 0, 0, 8);

      mode = 1;
      run(1'b0, 40);
      chk("abort_no_done", done_n, 0);
      chk("abort_idle_err", {16'd0, err_cnt}, 0);
      chk("abort_idle_busy", {31'd0, busy}, 0);

      mode = 2;
      run(1'b0, 0);
      check_run("after_abort", 0, 0, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
